// File: rtl/mips_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mips_pkg : shared encodings for the MIPS pipeline memory stage    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package mips_pkg;

   localparam int MEMOP_W_BITS = 3;

   localparam logic [MEMOP_W_BITS-1:0] MEMOP_W  = 3'b000;
   localparam logic [MEMOP_W_BITS-1:0] MEMOP_H  = 3'b001;
   localparam logic [MEMOP_W_BITS-1:0] MEMOP_HU = 3'b010;
   localparam logic [MEMOP_W_BITS-1:0] MEMOP_B  = 3'b011;
   localparam logic [MEMOP_W_BITS-1:0] MEMOP_BU = 3'b100;

endpackage
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_mem : word-organised data RAM, byte-enabled sync write,      |
// |            asynchronous read                                      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module data_mem #(
   parameter int ADDR_BITS = 10
) (
   input  logic                 Clk,
   input  logic [ADDR_BITS-1:0] Addr,
   input  logic [3:0]           ByteEn,
   input  logic [31:0]          WData,
   output logic [31:0]          RData
);

   logic [31:0] mem_q [0:(2**ADDR_BITS)-1];

   always_ff @(posedge Clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ByteEn[i]) begin
            mem_q[Addr][8*i +: 8] <= WData[8*i +: 8];
         end
      end
   end

   assign RData = mem_q[Addr];

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_wb_stage : MEM stage data access plus MEM/WB register         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mem_wb_stage
   import mips_pkg::*;
#(
   parameter int DM_ADDR_BITS = 10
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    RegWriteM,
   input  logic                    MemtoRegM,
   input  logic                    MemWriteM,
   input  logic [MEMOP_W_BITS-1:0] MemOpM,
   input  logic [31:0]             ALUResultM,
   input  logic [31:0]             WriteDataM,
   input  logic [4:0]              WriteRegM,
   output logic                    RegWriteW,
   output logic                    MemtoRegW,
   output logic [31:0]             ALUResultW,
   output logic [31:0]             ReadDataW,
   output logic [4:0]              WriteRegW,
   output logic [31:0]             ResultW,
   output logic                    AdErrW
);

   logic [DM_ADDR_BITS-1:0] word_idx;
   logic [1:0]              offset;
   logic [31:0]             mem_rdata;
   logic [31:0]             store_data;
   logic [3:0]              lane_en;
   logic [3:0]              byte_en;
   logic                    size_err;
   logic                    ad_err;
   logic [7:0]              load_byte;
   logic [15:0]             load_half;
   logic [31:0]             load_ext;

   logic        reg_write_d,  reg_write_q;
   logic        mem_to_reg_d, mem_to_reg_q;
   logic [31:0] alu_result_d, alu_result_q;
   logic [31:0] read_data_d,  read_data_q;
   logic [4:0]  write_reg_d,  write_reg_q;
   logic        ad_err_d,     ad_err_q;

   // Upper address bits are dropped here, so accesses wrap modulo memory size.
   assign word_idx = ALUResultM[DM_ADDR_BITS+1:2];
   assign offset   = ALUResultM[1:0];

   always_comb begin
      size_err   = 1'b0;
      lane_en    = 4'b1111;
      store_data = WriteDataM;
      load_ext   = mem_rdata;
      load_half  = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (offset)
         2'd0:    load_byte = mem_rdata[7:0];
         2'd1:    load_byte = mem_rdata[15:8];
         2'd2:    load_byte = mem_rdata[23:16];
         default: load_byte = mem_rdata[31:24];
      endcase

      case (MemOpM)
         MEMOP_H, MEMOP_HU: begin
            size_err   = offset[0];
            lane_en    = offset[1] ? 4'b1100 : 4'b0011;
            store_data = {2{WriteDataM[15:0]}};
            load_ext   = (MemOpM == MEMOP_H) ? {{16{load_half[15]}}, load_half}
                                             : {16'h0000, load_half};
         end
         MEMOP_B, MEMOP_BU: begin
            lane_en    = 4'b0001 << offset;
            store_data = {4{WriteDataM[7:0]}};
            load_ext   = (MemOpM == MEMOP_B) ? {{24{load_byte[7]}}, load_byte}
                                             : {24'h000000, load_byte};
         end
         default: begin
            size_err = (offset != 2'b00);
         end
      endcase

      // Non-memory ops carry don't-care address/op fields and must never flag.
      ad_err  = size_err & (MemWriteM | MemtoRegM);
      byte_en = (MemWriteM && !ad_err && !Reset) ? lane_en : 4'b0000;

      reg_write_d  = RegWriteM & ~ad_err;
      mem_to_reg_d = MemtoRegM;
      alu_result_d = ALUResultM;
      read_data_d  = ad_err ? 32'h0000_0000 : load_ext;
      write_reg_d  = WriteRegM;
      ad_err_d     = ad_err;
   end

   data_mem #(
      .ADDR_BITS (DM_ADDR_BITS)
   ) u_data_mem (
      .Clk    (Clk),
      .Addr   (word_idx),
      .ByteEn (byte_en),
      .WData  (store_data),
      .RData  (mem_rdata)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         alu_result_q <= 32'h0000_0000;
         read_data_q  <= 32'h0000_0000;
         write_reg_q  <= 5'd0;
         ad_err_q     <= 1'b0;
      end else begin
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         alu_result_q <= alu_result_d;
         read_data_q  <= read_data_d;
         write_reg_q  <= write_reg_d;
         ad_err_q     <= ad_err_d;
      end
   end

   assign RegWriteW  = reg_write_q;
   assign MemtoRegW  = mem_to_reg_q;
   assign ALUResultW = alu_result_q;
   assign ReadDataW  = read_data_q;
   assign WriteRegW  = write_reg_q;
   assign AdErrW     = ad_err_q;
   assign ResultW    = mem_to_reg_q ? read_data_q : alu_result_q;

endmodule
`default_nettype wire
